// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write/read pointer controllers.
// Pointer helpers work on a 32-bit container; callers zero-extend narrower
// pointers on the way in and size-cast the result on the way out.
package fifo_pkg;

  localparam int FIFO_PTR_W  = 4;
  localparam int FIFO_DATA_W = 8;
  localparam int PTR_MAX_W   = 32;

  // Binary to reflected Gray; width-agnostic as long as unused MSBs are zero.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Only one bit changes per source update, so a multi-bit capture is safe.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for the async FIFO (wclk domain).
// Owns the binary write pointer, publishes its Gray form to the read side,
// and derives full / almost-full / level / sticky overflow from the
// synchronized read pointer. Status is pessimistic while a read-pointer
// update is still crossing, so occupancy is never underreported.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int N         = FIFO_PTR_W,
  parameter int AF_MARGIN = 2
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         winc,
  input  logic [N-1:0] rptr_gray,
  input  logic         ovf_clr,
  output logic [N-2:0] waddr,
  output logic         wenable,
  output logic [N-1:0] wptr_gray,
  output logic         wfull,
  output logic         walmost_full,
  output logic [N-1:0] wlevel,
  output logic         woverflow
);

  localparam int           DEPTH     = 2 ** (N - 1);
  localparam logic [N-1:0] AF_THRESH = N'(DEPTH - AF_MARGIN);

  logic [N-1:0] wbin;
  logic [N-1:0] wbin_next;
  logic [N-1:0] wgray_next;
  logic [N-1:0] rq2;
  logic [N-1:0] rbin;
  logic [N-1:0] level_next;
  logic         full_next;
  logic         afull_next;
  logic         ovf_next;

  // Read pointer crosses into wclk through two flops; nothing else samples it.
  sync2 #(.W(N)) u_rsync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_gray),
    .q     (rq2)
  );

  // Accept only when not full; reset forces the strobe low regardless of winc.
  assign wenable = winc & ~wfull & wrst_n;
  assign waddr   = wbin[N-2:0];

  // Next-state pointer, level and flags all derive from the same wbin_next.
  always_comb begin
    wbin_next  = wbin + {{(N-1){1'b0}}, wenable};
    wgray_next = N'(bin2gray(PTR_MAX_W'(wbin_next)));
    rbin       = N'(gray2bin(PTR_MAX_W'(rq2)));
    level_next = wbin_next - rbin;
    // Full when the Gray pointers differ only in the top two bits.
    full_next  = (wgray_next == {~rq2[N-1:N-2], rq2[N-3:0]});
    afull_next = (level_next >= AF_THRESH);
    // A fresh overflow wins over a clear in the same cycle.
    ovf_next   = (winc & wfull) | (woverflow & ~ovf_clr);
  end

  // Pointer and status registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
      woverflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for the FIFO write-pointer controller.
module tb_fifo_wptr_ctrl;

  localparam int N = 4;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         winc;
  logic [N-1:0] rptr_gray;
  logic         ovf_clr;
  logic [N-2:0] waddr;
  logic         wenable;
  logic [N-1:0] wptr_gray;
  logic         wfull;
  logic         walmost_full;
  logic [N-1:0] wlevel;
  logic         woverflow;

  int ncmp  = 0;
  int nfail = 0;

  logic [3:0] fill_g [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
  logic [3:0] exp_g;
  logic [3:0] g_prev;
  logic [3:0] bb;
  logic [3:0] rb;

  fifo_wptr_ctrl #(.N(N), .AF_MARGIN(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wenable      (wenable),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_waddr"}, 32'(waddr), 0);
    check({tag, "_wgray"}, 32'(wptr_gray), 0);
    check({tag, "_wfull"}, 32'(wfull), 0);
    check({tag, "_afull"}, 32'(walmost_full), 0);
    check({tag, "_wlevel"}, 32'(wlevel), 0);
    check({tag, "_wovf"}, 32'(woverflow), 0);
  endtask

  initial begin
    wrst_n = 1'b0; winc = 1'b0; rptr_gray = '0; ovf_clr = 1'b0;
    step(); step();
    wrst_n = 1'b1;
    #1;
    check_zero("rst");

    // Write a few entries, then yank reset in the middle of a cycle.
    winc = 1'b1;
    step(); step(); step();
    check("pre_rst_level", 32'(wlevel), 3);
    check("pre_rst_gray", 32'(wptr_gray), 4'h2);
    #2;
    wrst_n = 1'b0;
    #1;
    check_zero("async_rst");
    check("rst_wen", 32'(wenable), 0);
    step();
    check("rst_hold_level", 32'(wlevel), 0);
    winc = 1'b0;
    step();
    wrst_n = 1'b1;
    #1;

    // Fill eight entries against a stationary read pointer.
    winc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("fill_waddr", 32'(waddr), i - 1);
      check("fill_wen", 32'(wenable), 1);
      step();
      check("fill_gray", 32'(wptr_gray), fill_g[i-1]);
      check("fill_level", 32'(wlevel), i);
      check("fill_afull", 32'(walmost_full), (i >= 6) ? 1 : 0);
      check("fill_full", 32'(wfull), (i == 8) ? 1 : 0);
    end

    // Keep writing while full: dropped, overflow sticks.
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ovf_wen", 32'(wenable), 0);
      step();
      check("ovf_waddr", 32'(waddr), 0);
      check("ovf_gray", 32'(wptr_gray), 4'hC);
      check("ovf_level", 32'(wlevel), 8);
      check("ovf_flag", 32'(woverflow), 1);
    end
    winc = 1'b0; ovf_clr = 1'b1;
    step();
    check("ovf_clr", 32'(woverflow), 0);
    winc = 1'b1; ovf_clr = 1'b1;
    step();
    check("ovf_prec", 32'(woverflow), 1);
    check("ovf_prec_gray", 32'(wptr_gray), 4'hC);
    winc = 1'b0; ovf_clr = 1'b0;
    step();

    // Read side frees one entry; full drops on the third edge.
    rptr_gray = 4'h1;
    step();
    check("rel_full1", 32'(wfull), 1);
    step();
    check("rel_full2", 32'(wfull), 1);
    check("rel_level2", 32'(wlevel), 8);
    step();
    check("rel_full3", 32'(wfull), 0);
    check("rel_level3", 32'(wlevel), 7);
    winc = 1'b1;
    #1;
    check("rel_waddr", 32'(waddr), 0);
    check("rel_wen", 32'(wenable), 1);
    step();
    check("rel_gray", 32'(wptr_gray), 4'hD);
    check("rel_refull", 32'(wfull), 1);
    check("rel_level", 32'(wlevel), 8);
    winc = 1'b0;

    // Streaming with the read pointer trailing four edges behind.
    wrst_n = 1'b0; rptr_gray = '0;
    step(); step();
    wrst_n = 1'b1;
    #1;
    g_prev = 4'h0;
    winc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      #1;
      check("wrap_waddr", 32'(waddr), (k - 1) % 8);
      check("wrap_wen", 32'(wenable), 1);
      check("wrap_full", 32'(wfull), 0);
      step();
      bb    = 4'(k % 16);
      exp_g = bb ^ (bb >> 1);
      check("wrap_gray", 32'(wptr_gray), exp_g);
      check("wrap_1bit", $countones(wptr_gray ^ g_prev), 1);
      g_prev = exp_g;
      rb = (k >= 4) ? 4'((k - 4) % 16) : 4'h0;
      rptr_gray = rb ^ (rb >> 1);
    end
    winc = 1'b0;
    step();
    check("wrap_end_full", 32'(wfull), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
